// File: rtl/seq_controller_mc.sv
// Multi-cycle Moore controller for the simple RISC datapath: ALU/MOV/MOVcc, LDR/STR with a
// req/ack memory handshake and timeout, HALT and illegal-op trapping.
module seq_controller_mc #(
  parameter int unsigned MEM_TIMEOUT   = 16,
  parameter bit          COND_EN       = 1'b1,
  parameter bit          STATUS_ON_ALL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic [1:0] shift_op,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  input  logic       mem_ack,
  output logic       waiting,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_addr,
  output logic       mem_req,
  output logic       mem_we,
  output logic       halted,
  output logic       illegal,
  output logic       mem_err
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  // Opcode-dependent output differences get their own states so outputs stay pure Moore.
  typedef enum logic [4:0] {
    StWait, StWrImm, StLdA, StLdB, StExecMov, StExecAlu, StExecCmp, StWrC, StCond,
    StAddr, StLdAdL, StLdAdS, StMemL, StMemS, StWrM, StHalt, StIll
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            in_mem, timeout, cond_true;

  assign in_mem  = (state_q == StMemL) || (state_q == StMemS);
  assign timeout = (MEM_TIMEOUT != 0) && in_mem && !mem_ack && (cnt_q == CntLast);
  assign cnt_d   = (in_mem && !mem_ack) ? cnt_q + 1'b1 : '0;

  always_comb begin
    cond_true = 1'b1;
    unique case (shift_op)
      2'b01:   cond_true = Z;
      2'b10:   cond_true = N;
      2'b11:   cond_true = V;
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    mem_err_d = mem_err_q;
    if (state_q == StWait && start) begin
      mem_err_d = 1'b0;
    end else if (timeout) begin
      mem_err_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait: begin
        if (start) begin
          case (opcode)
            3'b110: begin
              if (ALU_op == 2'b10)      state_d = StWrImm;
              else if (ALU_op == 2'b00) state_d = StLdB;
              else                      state_d = StIll;
            end
            3'b101, 3'b011, 3'b100: state_d = StLdA;
            3'b001:  state_d = COND_EN ? StCond : StIll;
            3'b111:  state_d = StHalt;
            default: state_d = StIll;
          endcase
        end
      end
      StLdA:     state_d = (opcode == 3'b101) ? StLdB : StAddr;
      StLdB: begin
        if (opcode == 3'b110)      state_d = StExecMov;
        else if (ALU_op == 2'b01)  state_d = StExecCmp;
        else                       state_d = StExecAlu;
      end
      StExecMov, StExecAlu: state_d = StWrC;
      StCond:    state_d = cond_true ? StWrImm : StWait;
      StAddr:    state_d = (opcode == 3'b100) ? StLdAdS : StLdAdL;
      StLdAdL:   state_d = StMemL;
      StLdAdS:   state_d = StMemS;
      StMemL: begin
        if (mem_ack)      state_d = StWrM;
        else if (timeout) state_d = StWait;
      end
      StMemS:    if (mem_ack || timeout) state_d = StWait;
      StHalt:    state_d = StHalt;
      default:   state_d = StWait;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StWait;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  always_comb begin
    waiting   = 1'b0;
    reg_sel   = 2'b00;
    wb_sel    = 2'b00;
    w_en      = 1'b0;
    en_A      = 1'b0;
    en_B      = 1'b0;
    en_C      = 1'b0;
    en_status = 1'b0;
    sel_A     = 1'b0;
    sel_B     = 1'b0;
    load_addr = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StWait:    waiting = 1'b1;
      StWrImm:   begin reg_sel = 2'b10; wb_sel = 2'b10; w_en = 1'b1; end
      StLdA:     begin reg_sel = 2'b10; en_A = 1'b1; end
      StLdB:     en_B = 1'b1;
      StExecMov: begin sel_A = 1'b1; en_C = 1'b1; end
      StExecAlu: begin en_C = 1'b1; en_status = STATUS_ON_ALL; end
      StExecCmp: begin en_C = 1'b1; en_status = 1'b1; end
      StWrC:     begin reg_sel = 2'b01; w_en = 1'b1; end
      StAddr:    begin sel_B = 1'b1; en_C = 1'b1; end
      StLdAdL:   load_addr = 1'b1;
      StLdAdS:   begin load_addr = 1'b1; reg_sel = 2'b01; en_B = 1'b1; end
      StMemL:    mem_req = 1'b1;
      StMemS:    begin mem_req = 1'b1; mem_we = 1'b1; end
      StWrM:     begin reg_sel = 2'b01; wb_sel = 2'b11; w_en = 1'b1; end
      StHalt:    halted = 1'b1;
      StIll:     illegal = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_seq_controller_mc.sv
// Randomized bench for seq_controller_mc: each instruction is expanded by a reference model into
// the expected per-cycle output vectors, which are compared against the DUT cycle by cycle.
module tb_seq_controller_mc;

  localparam int unsigned Tmo   = 16;
  localparam bit          StAll = 1'b0;

  logic       clk, rst_n, start, Z, N, V, mem_ack;
  logic [2:0] opcode;
  logic [1:0] ALU_op, shift_op, reg_sel, wb_sel;
  logic       waiting, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, load_addr;
  logic       mem_req, mem_we, halted, illegal, mem_err;

  seq_controller_mc #(.MEM_TIMEOUT(Tmo), .COND_EN(1'b1), .STATUS_ON_ALL(StAll)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
    .shift_op(shift_op), .Z(Z), .N(N), .V(V), .mem_ack(mem_ack), .waiting(waiting),
    .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C),
    .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B), .load_addr(load_addr),
    .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .illegal(illegal), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
  // sel_A, sel_B, load_addr, mem_req, mem_we, halted, illegal, mem_err.
  localparam logic [17:0] WAITING = 18'h20000, W_EN = 18'h01000, EN_A = 18'h00800;
  localparam logic [17:0] EN_B = 18'h00400, EN_C = 18'h00200, EN_ST = 18'h00100;
  localparam logic [17:0] SEL_A = 18'h00080, SEL_B = 18'h00040, LD_ADDR = 18'h00020;
  localparam logic [17:0] MREQ = 18'h00010, MWE = 18'h00008, HALT = 18'h00004;
  localparam logic [17:0] ILL = 18'h00002, MERR = 18'h00001;

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] expq[$];
  bit          ackq[$];
  bit          err_m = 1'b0;

  function automatic logic [17:0] rs(int x);
    return 18'(x) << 15;
  endfunction

  function automatic logic [17:0] ws(int x);
    return 18'(x) << 13;
  endfunction

  function automatic logic [17:0] obs();
    return {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
            load_addr, mem_req, mem_we, halted, illegal, mem_err};
  endfunction

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  task automatic push(input logic [17:0] v, input bit ack);
    expq.push_back(v | (err_m ? MERR : 18'h0));
    ackq.push_back(ack);
  endtask

  task automatic push_r(input logic [17:0] v);
    push(v, 1'($urandom_range(0, 1)));
  endtask

  // d = MEM cycle (1-based) on which mem_ack is raised; outside 1..Tmo means never.
  task automatic model(input logic [2:0] opc, input logic [1:0] aop, input logic [1:0] cnd,
                       input bit z, input bit n, input bit v, input int d);
    bit st, acked, ct;
    int cycles;
    err_m = 1'b0;
    case (opc)
      3'b110: begin
        if (aop == 2'd2) push_r(rs(2) | ws(2) | W_EN);
        else if (aop == 2'd0) begin
          push_r(EN_B); push_r(SEL_A | EN_C); push_r(rs(1) | W_EN);
        end else push_r(ILL);
      end
      3'b101: begin
        push_r(rs(2) | EN_A);
        push_r(EN_B);
        push_r(EN_C | ((aop == 2'd1 || StAll) ? EN_ST : 18'h0));
        if (aop != 2'd1) push_r(rs(1) | W_EN);
      end
      3'b001: begin
        ct = (cnd == 2'd0) || (cnd == 2'd1 && z) || (cnd == 2'd2 && n) || (cnd == 2'd3 && v);
        push_r(18'h0);
        if (ct) push_r(rs(2) | ws(2) | W_EN);
      end
      3'b011, 3'b100: begin
        st     = (opc == 3'b100);
        acked  = (d >= 1) && (d <= int'(Tmo));
        cycles = acked ? d : int'(Tmo);
        push_r(rs(2) | EN_A);
        push_r(SEL_B | EN_C);
        push_r(LD_ADDR | (st ? (rs(1) | EN_B) : 18'h0));
        for (int j = 1; j <= cycles; j++) push(MREQ | (st ? MWE : 18'h0), j == d);
        if (acked && !st) push_r(rs(1) | ws(3) | W_EN);
        if (!acked) err_m = 1'b1;
      end
      default: push_r(ILL);
    endcase
    push_r(WAITING);
  endtask

  // Called at a negedge with the DUT in WAIT; returns at the negedge where WAIT is checked again.
  task automatic run(input string tag, input logic [2:0] opc, input logic [1:0] aop,
                     input logic [1:0] cnd, input bit z, input bit n, input bit v, input int d);
    expq.delete();
    ackq.delete();
    model(opc, aop, cnd, z, n, v, d);
    opcode = opc; ALU_op = aop; shift_op = cnd; Z = z; N = n; V = v;
    start = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    foreach (expq[i]) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("%s[%0d]", tag, i), obs(), expq[i]);
      mem_ack = ackq[i];
    end
    mem_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 3'($urandom); ALU_op = 2'($urandom); Z = 1'($urandom);
      @(negedge clk);
      check("idle", obs(), WAITING | (err_m ? MERR : 18'h0));
    end
  endtask

  initial begin
    logic [2:0] opc;
    rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; opcode = 3'b000; ALU_op = 2'b00;
    shift_op = 2'b00; Z = 1'b0; N = 1'b0; V = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", obs(), WAITING);
    rst_n = 1'b1;
    idle(1);

    run("mov_imm", 3'b110, 2'b10, 2'b00, 0, 0, 0, 0);
    run("add",     3'b101, 2'b00, 2'b00, 0, 0, 0, 0);
    run("cmp",     3'b101, 2'b01, 2'b00, 0, 0, 0, 0);
    run("movcc_z0", 3'b001, 2'b00, 2'b01, 0, 1, 1, 0);
    run("movcc_z1", 3'b001, 2'b00, 2'b01, 1, 0, 0, 0);
    run("ldr_ack3", 3'b011, 2'b00, 2'b00, 0, 0, 0, 3);
    run("str_tmo",  3'b100, 2'b00, 2'b00, 0, 0, 0, 0);
    idle(2);

    // Reset asserted mid-MEM on a store must drop mem_req without waiting for a clock.
    opcode = 3'b100; start = 1'b1; mem_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("str_in_mem", obs(), MREQ | MWE);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_mem", obs(), WAITING);
    err_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    for (int k = 0; k < 80; k++) begin
      opc = 3'($urandom_range(0, 6));
      run($sformatf("rnd%0d_op%0d", k, opc), opc, 2'($urandom), 2'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 20));
      idle($urandom_range(0, 2));
    end

    opcode = 3'b111; start = 1'b1;
    @(negedge clk);
    check("halt", obs(), HALT);
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); opcode = 3'($urandom); mem_ack = 1'($urandom);
      @(negedge clk);
      check("halt_hold", obs(), HALT);
    end
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("halt_reset", obs(), WAITING);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
